// File: rtl/spike_frame_fifo.sv
// Spike-address FIFO (AXI4-Stream) that tags each entry with a frame-end flag and counts complete frames.
// Latency: a beat stored at edge N is visible on m_* (first-word-fall-through) right after edge N.
// Backpressure: s_tready = !o_full, or always 1 with DROP_ON_FULL=1 (beats arriving while full are discarded).
//
// Ports:
//   clk, rst (synchronous, active-high), i_flush (empties the FIFO in one cycle)
//   s_tvalid/s_tready/s_tdata/s_tlast : input spike-address stream
//   m_tvalid/m_tready/m_tdata/m_tlast : output stream, head entry shown while non-empty, zeros when empty
//   o_count, o_frames_avail           : occupancy and number of complete buffered frames
//   o_full, o_empty                   : occupancy flags (from the pointers)
//   o_drop_count                      : saturating count of discarded beats (kept across flush)
//
// Optional feature macro: SPIKE_FIFO_ADDR_CHECK_EN -- when defined, beats with s_tdata >= NUM_INPUTS
// are discarded and counted as drops; when undefined every address is stored.

module spike_frame_fifo #(
    parameter int DATA_WIDTH     = 14,
    parameter int DEPTH          = 256,
    parameter int CNT_WIDTH      = $clog2(DEPTH) + 1,
    parameter int DROP_ON_FULL   = 0,
    parameter int NUM_INPUTS     = 10000,
    parameter int DROP_CTR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic                      s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic                      m_tlast,
    output logic [CNT_WIDTH-1:0]      o_count,
    output logic [CNT_WIDTH-1:0]      o_frames_avail,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [DROP_CTR_WIDTH-1:0] o_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [AW-1:0]        IDX_ONE = AW'(1);

    // Address limit widened by one bit so that a NUM_INPUTS beyond the address
    // range simply means "every address is valid".
    localparam logic [DATA_WIDTH:0] NUM_LIM =
        (NUM_INPUTS >= (2 ** DATA_WIDTH)) ? (DATA_WIDTH + 1)'(2 ** DATA_WIDTH)
                                          : (DATA_WIDTH + 1)'(NUM_INPUTS);

`ifdef SPIKE_FIFO_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    // Each entry is {last, addr}.
    logic [DATA_WIDTH:0]       mem [DEPTH];

    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [CNT_WIDTH-1:0]      count;
    logic [CNT_WIDTH-1:0]      frames;
    logic [DROP_CTR_WIDTH-1:0] drop_cnt;

    logic [DATA_WIDTH:0]       head;
    logic [AW-1:0]             newest_idx;
    logic                      newest_last;
    logic                      wr_hs;
    logic                      addr_ok;
    logic                      store;
    logic                      drop;
    logic                      pop;
    logic                      target_ok;
    logic                      promote;
    logic                      frame_inc;
    logic                      frame_dec;

    // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign s_tready = (DROP_ON_FULL != 0) || !o_full;

    assign head     = mem[rd_ptr[AW-1:0]];
    assign m_tvalid = !o_empty;
    assign m_tdata  = o_empty ? '0 : head[DATA_WIDTH-1:0];
    assign m_tlast  = !o_empty && head[DATA_WIDTH];

    assign o_count        = count;
    assign o_frames_avail = frames;
    assign o_drop_count   = drop_cnt;

    assign newest_idx  = wr_ptr[AW-1:0] - IDX_ONE;
    assign newest_last = mem[newest_idx][DATA_WIDTH];

    assign wr_hs   = s_tvalid && s_tready;
    assign addr_ok = !ADDR_CHECK || ({1'b0, s_tdata} < NUM_LIM);
    // No write-through: fullness is judged on the state at the start of the cycle.
    assign store   = wr_hs && !o_full && addr_ok;
    assign drop    = wr_hs && (o_full || !addr_ok);
    assign pop     = m_tvalid && m_tready;

    // A dropped frame end moves onto the newest entry, provided that entry
    // survives this cycle's pop. When full it always does (DEPTH >= 4 keeps
    // head and newest apart). An entry that already ends a frame absorbs it
    // without creating a second frame.
    assign target_ok = (count != '0) && !((count == CNT_ONE) && pop);
    assign promote   = drop && s_tlast && target_ok && !newest_last;

    assign frame_inc = (store && s_tlast) || promote;
    assign frame_dec = pop && m_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            frames   <= '0;
            drop_cnt <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            frames <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({store, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            case ({frame_inc, frame_dec})
                2'b10:   frames <= frames + CNT_ONE;
                2'b01:   frames <= frames - CNT_ONE;
                default: frames <= frames;
            endcase
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Storage array carries no reset; store and promote never coincide
    // because a beat is either stored or dropped.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            if (store) begin
                mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
            end else if (promote) begin
                mem[newest_idx][DATA_WIDTH] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_frame_fifo.sv
module tb_spike_frame_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Instance a: DEPTH=8, backpressure mode
    logic        a_flush = 1'b0, a_sv = 1'b0, a_sl = 1'b0, a_mr = 1'b0;
    logic [13:0] a_sd = '0;
    logic        a_sr, a_mv, a_ml, a_full, a_empty;
    logic [13:0] a_md;
    logic [3:0]  a_cnt, a_fr;
    logic [15:0] a_drop;

    // Instance b: DEPTH=8, drop-on-full mode
    logic        b_flush = 1'b0, b_sv = 1'b0, b_sl = 1'b0, b_mr = 1'b0;
    logic [13:0] b_sd = '0;
    logic        b_sr, b_mv, b_ml, b_full, b_empty;
    logic [13:0] b_md;
    logic [3:0]  b_cnt, b_fr;
    logic [15:0] b_drop;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spike_frame_fifo #(
        .DATA_WIDTH(14), .DEPTH(8), .CNT_WIDTH(4), .DROP_ON_FULL(0),
        .NUM_INPUTS(10000), .DROP_CTR_WIDTH(16)
    ) u_a (
        .clk(clk), .rst(rst), .i_flush(a_flush),
        .s_tvalid(a_sv), .s_tready(a_sr), .s_tdata(a_sd), .s_tlast(a_sl),
        .m_tvalid(a_mv), .m_tready(a_mr), .m_tdata(a_md), .m_tlast(a_ml),
        .o_count(a_cnt), .o_frames_avail(a_fr), .o_full(a_full), .o_empty(a_empty),
        .o_drop_count(a_drop)
    );

    spike_frame_fifo #(
        .DATA_WIDTH(14), .DEPTH(8), .CNT_WIDTH(4), .DROP_ON_FULL(1),
        .NUM_INPUTS(10000), .DROP_CTR_WIDTH(16)
    ) u_b (
        .clk(clk), .rst(rst), .i_flush(b_flush),
        .s_tvalid(b_sv), .s_tready(b_sr), .s_tdata(b_sd), .s_tlast(b_sl),
        .m_tvalid(b_mv), .m_tready(b_mr), .m_tdata(b_md), .m_tlast(b_ml),
        .o_count(b_cnt), .o_frames_avail(b_fr), .o_full(b_full), .o_empty(b_empty),
        .o_drop_count(b_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_a_tready", 32'(a_sr), 1);
        chk("rst_a_tvalid", 32'(a_mv), 0);
        chk("rst_a_tdata",  32'(a_md), 0);
        chk("rst_a_tlast",  32'(a_ml), 0);
        chk("rst_a_count",  32'(a_cnt), 0);
        chk("rst_a_frames", 32'(a_fr), 0);
        chk("rst_a_full",   32'(a_full), 0);
        chk("rst_a_empty",  32'(a_empty), 1);
        chk("rst_a_drop",   32'(a_drop), 0);
        chk("rst_b_tready", 32'(b_sr), 1);

        // ---------------- frame counting ----------------
        a_sv = 1'b1; a_sl = 1'b0; a_sd = 14'd5;  step();
        a_sd = 14'd9;  step();
        a_sd = 14'd12; a_sl = 1'b1; step();
        a_sv = 1'b0; a_sl = 1'b0;
        chk("fc_count",  32'(a_cnt), 3);
        chk("fc_frames", 32'(a_fr), 1);
        chk("fc_head",   32'(a_md), 5);
        a_mr = 1'b1;
        chk("fc_pop0_data", 32'(a_md), 5);
        chk("fc_pop0_last", 32'(a_ml), 0);
        step();
        chk("fc_pop1_data", 32'(a_md), 9);
        chk("fc_pop1_last", 32'(a_ml), 0);
        step();
        chk("fc_pop2_data", 32'(a_md), 12);
        chk("fc_pop2_last", 32'(a_ml), 1);
        step();
        a_mr = 1'b0;
        chk("fc_end_frames", 32'(a_fr), 0);
        chk("fc_end_empty",  32'(a_empty), 1);
        chk("fc_end_tvalid", 32'(a_mv), 0);

        // ---------------- full with backpressure ----------------
        for (int i = 0; i < 10; i++) begin
            a_sv = 1'b1; a_sd = 14'(100 + i);
            step();
            if (i == 6) chk("bp_ready_after7", 32'(a_sr), 1);
        end
        a_sv = 1'b0;
        chk("bp_tready", 32'(a_sr), 0);
        chk("bp_full",   32'(a_full), 1);
        chk("bp_count",  32'(a_cnt), 8);
        chk("bp_drop",   32'(a_drop), 0);
        a_mr = 1'b1; step(); a_mr = 1'b0;
        chk("bp_ready_after_pop", 32'(a_sr), 1);
        chk("bp_head_after_pop",  32'(a_md), 101);
        a_mr = 1'b1; step(); step(); a_mr = 1'b0;
        chk("bp_count5", 32'(a_cnt), 5);

        // ---------------- flush with concurrent write ----------------
        a_flush = 1'b1; a_sv = 1'b1; a_sd = 14'd7; step();
        a_flush = 1'b0; a_sv = 1'b0;
        chk("fl_a_count",  32'(a_cnt), 0);
        chk("fl_a_empty",  32'(a_empty), 1);
        chk("fl_a_tvalid", 32'(a_mv), 0);

        // ---------------- simultaneous push/pop at count 4 ----------------
        a_sv = 1'b1;
        a_sd = 14'd20; a_sl = 1'b1; step();
        a_sl = 1'b0;
        a_sd = 14'd21; step();
        a_sd = 14'd22; step();
        a_sd = 14'd23; step();
        chk("pp_count_pre",  32'(a_cnt), 4);
        chk("pp_frames_pre", 32'(a_fr), 1);
        a_sd = 14'd24; a_sl = 1'b1; a_mr = 1'b1;
        chk("pp_head_last", 32'(a_ml), 1);
        step();
        chk("pp_last_count",  32'(a_cnt), 4);
        chk("pp_last_frames", 32'(a_fr), 1);
        chk("pp_last_head",   32'(a_md), 21);
        a_sd = 14'd25; a_sl = 1'b0;
        step();
        a_sv = 1'b0; a_mr = 1'b0;
        chk("pp_plain_count",  32'(a_cnt), 4);
        chk("pp_plain_frames", 32'(a_fr), 1);
        chk("pp_plain_head",   32'(a_md), 22);
        a_flush = 1'b1; step(); a_flush = 1'b0;

        // ---------------- address range ----------------
        a_sv = 1'b1; a_sl = 1'b0;
        a_sd = 14'd9999;  step();
        a_sd = 14'd10000; step();
        a_sd = 14'd16383; step();
        a_sv = 1'b0;
        chk("ac_head", 32'(a_md), 9999);
`ifdef SPIKE_FIFO_ADDR_CHECK_EN
        chk("ac_count", 32'(a_cnt), 1);
        chk("ac_drop",  32'(a_drop), 2);
`else
        chk("ac_count", 32'(a_cnt), 3);
        chk("ac_drop",  32'(a_drop), 0);
`endif

        // ---------------- drop-on-full ----------------
        b_sv = 1'b1; b_sl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_sd = 14'(30 + i);
            step();
        end
        b_sd = 14'd38; step();
        chk("dr_tready_full", 32'(b_sr), 1);
        chk("dr_full",        32'(b_full), 1);
        chk("dr_frames_pre",  32'(b_fr), 0);
        b_sd = 14'd39; b_sl = 1'b1; step();
        b_sv = 1'b0; b_sl = 1'b0;
        chk("dr_drop",   32'(b_drop), 2);
        chk("dr_frames", 32'(b_fr), 1);
        chk("dr_count",  32'(b_cnt), 8);
        b_mr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("dr_rd_data", 32'(b_md), 32'(30 + i));
            chk("dr_rd_last", 32'(b_ml), 32'(i == 7));
            step();
        end
        b_mr = 1'b0;
        chk("dr_end_frames", 32'(b_fr), 0);
        chk("dr_end_empty",  32'(b_empty), 1);

        // ---------------- flush keeps drop count ----------------
        b_sv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_sd = 14'(40 + i);
            step();
        end
        chk("fl_b_count_pre", 32'(b_cnt), 5);
        b_flush = 1'b1; b_sd = 14'd50; step();
        b_flush = 1'b0; b_sv = 1'b0;
        chk("fl_b_count", 32'(b_cnt), 0);
        chk("fl_b_empty", 32'(b_empty), 1);
        chk("fl_b_drop",  32'(b_drop), 2);
        step();
        chk("fl_b_beat_lost", 32'(b_empty), 1);

        // ---------------- reset mid-stream ----------------
        b_sv = 1'b1; b_sd = 14'd51; step();
        a_sv = 1'b1; a_sd = 14'd60; a_flush = 1'b1;
        rst = 1'b1; step();
        rst = 1'b0; a_sv = 1'b0; a_flush = 1'b0; b_sv = 1'b0;
        chk("mr_a_tready", 32'(a_sr), 1);
        chk("mr_a_tvalid", 32'(a_mv), 0);
        chk("mr_a_tdata",  32'(a_md), 0);
        chk("mr_a_count",  32'(a_cnt), 0);
        chk("mr_a_empty",  32'(a_empty), 1);
        chk("mr_a_drop",   32'(a_drop), 0);
        chk("mr_b_count",  32'(b_cnt), 0);
        chk("mr_b_frames", 32'(b_fr), 0);
        chk("mr_b_tlast",  32'(b_ml), 0);
        chk("mr_b_full",   32'(b_full), 0);
        chk("mr_b_drop",   32'(b_drop), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spike_frame_fifo.md
# spike_frame_fifo

Parametrised successor to the spike address FIFO: an AXI4-Stream spike-address buffer that stores a per-entry frame-end flag and counts complete frames. The source controller can start processing a frame as soon as one is fully buffered, instead of waiting for the input to go idle. It sits between the external spike stream and the source controller, replacing the plain FIFO plus the top-level input-complete logic. It adds a flush control, an optional drop-on-full mode, and saturating drop statistics.

## Interface
- DATA_WIDTH, 14: spike address width.
- DEPTH, 256: entries; power of two, at least 4.
- CNT_WIDTH, $clog2(DEPTH)+1: width of the occupancy and frame counts.
- DROP_ON_FULL, 0: 0 applies backpressure when full; 1 keeps s_tready=1 and discards beats that arrive while full.
- NUM_INPUTS, 10000: number of valid addresses, used only by the range check.
- DROP_CTR_WIDTH, 16: width of the drop counter.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i_flush  in  1  empties the FIFO in one cycle.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input ready.
- s_tdata  in  DATA_WIDTH  spike address.
- s_tlast  in  1  last beat of the frame.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  consumer ready.
- m_tdata  out  DATA_WIDTH  head address.
- m_tlast  out  1  head entry's frame-end flag.
- o_count  out  CNT_WIDTH  occupancy.
- o_frames_avail  out  CNT_WIDTH  complete frames buffered.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.
- o_drop_count  out  DROP_CTR_WIDTH  discarded beats, saturating.

## Operation
**Storage**
- Each entry holds {last, addr}.
- Read and write pointers are $clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty on wrap-around.

**Output (first-word-fall-through)**
- m_tvalid = !o_empty.
- m_tdata and m_tlast show the head entry.
- Both are forced to 0 when empty.

**Write acceptance**
- s_tready = !o_full when DROP_ON_FULL=0, and 1 when DROP_ON_FULL=1.
- A beat handshakes when s_tvalid && s_tready.
- The beat is stored only if o_full was 0 at the start of the cycle.
- There is no write-through when full: a simultaneous pop does not make room in the same cycle.

**Drop mode (DROP_ON_FULL=1)**
- A beat that handshakes while full is discarded and o_drop_count increments.
- If the discarded beat has s_tlast=1, the last flag is set on the newest stored entry at wr_ptr-1, which is still unread because DEPTH≥4, and the frame is counted.

**Pop**
- A pop occurs when m_tvalid && m_tready.

**Counters**
- o_count: +1 on store, -1 on pop, unchanged when both happen in the same cycle.
- o_frames_avail: +1 when an entry gains a last flag (stored with last, or promoted from a dropped tlast beat), -1 on a pop with m_tlast=1, unchanged when both happen.
- o_frames_avail never exceeds o_count.
- o_drop_count saturates at all-ones.

**Flush**
- i_flush resets both pointers, o_count and o_frames_avail to 0.
- It takes priority over a store or pop in the same cycle; that beat is lost and is not counted as dropped.
- o_drop_count is kept.

**Reset**
- rst has priority over i_flush.
- It clears all state including o_drop_count.
- Memory contents are not reset.

## Timing
- Write to read latency is 1 cycle: a beat stored at edge N makes m_tvalid high after edge N.
- o_count, o_frames_avail, o_full and o_empty are registered or derived from registers, and all update at the same edge as the store or pop.
- s_tready is combinational from registered o_full; it has no combinational path from s_tvalid or m_tready.
- Values after reset:
  - s_tready=1, m_tvalid=0, m_tdata=0, m_tlast=0.
  - o_count=0, o_frames_avail=0, o_full=0, o_empty=1, o_drop_count=0.
- Sustained throughput is one write plus one read per cycle.

## Configuration
- SPIKE_FIFO_ADDR_CHECK_EN defined: a handshaken beat with s_tdata ≥ NUM_INPUTS is discarded and increments o_drop_count.
  - Its tlast is promoted to the newest unread entry when one remains after this cycle's pop.
  - Otherwise the frame end is discarded and o_frames_avail is unchanged.
- SPIKE_FIFO_ADDR_CHECK_EN undefined: every address is stored unchecked and NUM_INPUTS is unused.

## Test plan
- Frame counting (DEPTH=8): write addresses 5, 9, 12 with tlast on 12, m_tready=0.
  - Required: o_count=3, o_frames_avail=1.
  - Then pop all three: order 5, 9, 12; m_tlast=1 on 12 only; o_frames_avail=0.
- Full with backpressure (DEPTH=8, DROP_ON_FULL=0): 10 back-to-back beats, m_tready=0.
  - Required: s_tready drops after the 8th beat; o_full=1; o_drop_count=0.
  - Then one pop: s_tready=1 on the next cycle.
- Drop mode (DROP_ON_FULL=1, DEPTH=8): fill with 8 non-last beats, then send 2 more with tlast on the 10th.
  - Required: o_drop_count=2, o_frames_avail=1, 8th entry read back with m_tlast=1.
- Simultaneous push and pop at o_count=4: o_count stays 4.
  - Push with last and pop with last in the same cycle: o_frames_avail unchanged.
- Flush and reset mid-stream: i_flush at o_count=5 with a concurrent write.
  - Required next cycle: o_count=0, o_empty=1, o_drop_count kept.
  - rst mid-stream: all outputs at reset values.
- SPIKE_FIFO_ADDR_CHECK_EN defined, NUM_INPUTS=10000: send 9999, 10000, 16383.
  - Required: only 9999 stored; o_drop_count=2.
